keypad_scanner: RTL and testbench

- Input-side counterpart to the multiplexed seven-segment display driver.
- Scans a 4x4 matrix keypad (Pmod KYPD) by driving one column low at a time and sampling the four row lines.
- Debounces the first key detected and produces a one-cycle key_valid strobe with a 4-bit hex key code.
- Feeds the game controller: board-cell selection and reset/confirm keys.

---
 rtl/keypad_scanner.sv | 163 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounced one-shot key strobe
//
// Purpose: drives one keypad column low at a time, samples the active-low row
// lines at the end of each column dwell, debounces the first key found and
// reports it once as a hex code with a single-cycle strobe.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   row[3:0]  keypad rows, active-low, asynchronous to clk
//   col[3:0]  keypad column drives, active-low, exactly one bit low
//   key_code  hex code of the last accepted key
//   key_valid one-cycle strobe marking a newly accepted key
//   key_down  high from acceptance until the debounced release
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state, state_next;
  logic [3:0]    row_meta, rs;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [1:0]    col_idx, row_idx;
  logic [CW-1:0] cnt, rel_cnt;
  logic          accept, release_done;

  // Lowest-numbered low row wins, so r0 has priority over r3.
  function automatic logic [1:0] first_low(input logic [3:0] r);
    if (!r[0])      first_low = 2'd0;
    else if (!r[1]) first_low = 2'd1;
    else if (!r[2]) first_low = 2'd2;
    else            first_low = 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  assign tick = (tcnt == TW'(SCAN_TICKS - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SCAN;
    else          state <= state_next;
  end

  // Next-state logic. The terminal sample is detected on the tick that would
  // bring a counter to DEBOUNCE_SCANS, so the registered outputs change on the
  // cycle right after the count is reached.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    release_done = 1'b0;
    case (state)
      SCAN: begin
        if (tick && rs != 4'hF) state_next = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (tick) begin
          if (rs[row_idx]) begin
            state_next = SCAN;
          end else if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
            state_next = HELD;
            accept     = 1'b1;
          end
        end
      end
      HELD: begin
        if (tick && rs[row_idx] && rel_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
          state_next   = SCAN;
          release_done = 1'b1;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // Synchroniser, tick timer, scan/debounce counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta  <= 4'hF;
      rs        <= 4'hF;
      tcnt      <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cnt       <= '0;
      rel_cnt   <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      row_meta  <= row;
      rs        <= row_meta;
      tcnt      <= tick ? '0 : tcnt + TW'(1);
      key_valid <= accept;
      if (accept) begin
        key_code <= key_map(row_idx, col_idx);
        key_down <= 1'b1;
      end else if (release_done) begin
        key_down <= 1'b0;
      end

      if (tick) begin
        case (state)
          SCAN: begin
            if (rs == 4'hF) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              row_idx <= first_low(rs);
              cnt     <= CW'(1);
            end
          end
          DEBOUNCE: begin
            if (!rs[row_idx]) begin
              cnt <= cnt + CW'(1);
              if (accept) rel_cnt <= '0;
            end else begin
              cnt     <= '0;
              col_idx <= col_idx + 2'd1;
            end
          end
          HELD: begin
            if (release_done) begin
              rel_cnt <= '0;
              cnt     <= '0;
              col_idx <= col_idx + 2'd1;
            end else if (rs[row_idx]) begin
              rel_cnt <= rel_cnt + CW'(1);
            end else begin
              rel_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output logic: column drive follows the column index directly
  always_comb begin
    col = ~(4'b0001 << col_idx);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with passive keypad model
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] pressed = '0;  // bit r*4+c
  logic [3:0]  exp_q[$];
  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .reset_n(reset_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
  end

  // Scoreboard: every strobe must match the oldest expected key
  always @(negedge clk) begin
    if (key_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: key_code=%h, required no strobe", key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key_code !== e) begin
          errors++;
          $display("FAIL strobe_code: key_code=%h, required %h", key_code, e);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (col !== 4'b1110 || key_valid !== 1'b0 || key_down !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL %s: col=%b kv=%b kd=%b code=%h, required 1110 0 0 0",
               tag, col, key_valid, key_down, key_code);
    end
  endtask

  task automatic wait_col_edge(input logic [3:0] v);
    logic [3:0] prev;
    prev = col;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col === v && prev !== v) return;
      prev = col;
    end
    checks++; errors++;
    $display("FAIL col_wait: col=%b, required transition to %b", col, v);
  endtask

  task automatic wait_strobe(input int budget, input logic [3:0] code);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid) begin
        checks++;
        if (key_down !== 1'b1) begin
          errors++;
          $display("FAIL strobe_key_down: key_down=%b, required 1", key_down);
        end
        return;
      end
    end
    checks++; errors++;
    $display("FAIL strobe_timeout: no key_valid, required strobe for %h", code);
  endtask

  task automatic wait_release(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!key_down) return;
    end
    checks++; errors++;
    $display("FAIL release_timeout: key_down=%b, required 0", key_down);
  endtask

  task automatic test_reset;
    logic [3:0] cols [4];
    cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    reset_n = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      checks++;
      if (col !== cols[(j / 4) % 4] || key_valid !== 1'b0 || key_down !== 1'b0 || key_code !== 4'h0) begin
        errors++;
        $display("FAIL scan_rotate[%0d]: col=%b kv=%b kd=%b code=%h, required col %b, others 0",
                 j, col, key_valid, key_down, key_code, cols[(j / 4) % 4]);
      end
    end
  endtask

  task automatic test_press;
    wait_col_edge(4'b1101);
    pressed[1*4+1] = 1'b1;
    exp_q.push_back(4'h5);
    repeat (11) @(negedge clk);
    checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b0) begin
      errors++;
      $display("FAIL press_early: kv=%b kd=%b, required 0 0", key_valid, key_down);
    end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h5 || key_down !== 1'b1) begin
      errors++;
      $display("FAIL press_accept: kv=%b code=%h kd=%b, required 1 5 1", key_valid, key_code, key_down);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (col !== 4'b1101 || key_down !== 1'b1 || key_code !== 4'h5) begin
      errors++;
      $display("FAIL press_hold: col=%b kd=%b code=%h, required 1101 1 5", col, key_down, key_code);
    end
  endtask

  // Entered on the negedge right after a tick, so each 4-cycle wait is one sample.
  task automatic test_release;
    pressed[1*4+1] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (key_down !== 1'b1) begin
      errors++;
      $display("FAIL release_two_high: key_down=%b, required 1", key_down);
    end
    pressed[1*4+1] = 1'b1;
    repeat (4) @(negedge clk);
    pressed[1*4+1] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (key_down !== 1'b1) begin
      errors++;
      $display("FAIL release_before_third: key_down=%b, required 1", key_down);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (key_down !== 1'b0 || col !== 4'b1011 || key_code !== 4'h5) begin
      errors++;
      $display("FAIL release_done: kd=%b col=%b code=%h, required 0 1011 5", key_down, col, key_code);
    end
  endtask

  task automatic test_bounce;
    wait_col_edge(4'b1011);
    pressed[2*4+2] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (col !== 4'b1011) begin
      errors++;
      $display("FAIL bounce_frozen: col=%b, required 1011", col);
    end
    pressed[2*4+2] = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (col !== 4'b0111 || key_down !== 1'b0 || key_code !== 4'h5) begin
      errors++;
      $display("FAIL bounce_resume: col=%b kd=%b code=%h, required 0111 0 5", col, key_down, key_code);
    end
  endtask

  task automatic test_simultaneous;
    wait_col_edge(4'b1011);
    pressed[1*4+2] = 1'b1;
    pressed[3*4+2] = 1'b1;
    exp_q.push_back(4'h6);
    wait_strobe(64, 4'h6);
    pressed = '0;
    wait_release(64);
    reset_n = 1'b0;
    @(negedge clk);
    pressed[0*4+0] = 1'b1;
    pressed[3*4+3] = 1'b1;
    exp_q.push_back(4'h1);
    reset_n = 1'b1;
    wait_strobe(64, 4'h1);
    pressed = '0;
    wait_release(64);
  endtask

  task automatic test_reset_mid;
    wait_col_edge(4'b0111);
    pressed[0*4+3] = 1'b1;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset_immediate");
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset_held");
    pressed = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (key_down !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL midreset_after: kd=%b code=%h, required 0 0", key_down, key_code);
    end
    pressed[0*4+3] = 1'b1;
    exp_q.push_back(4'hA);
    wait_strobe(96, 4'hA);
    pressed = '0;
    wait_release(64);
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d strobes missing, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
